instr_mem_controller: RTL and testbench

Arbitrates the GPU's per-channel instruction-fetch read requests onto a single instruction-memory read port, one outstanding transaction at a time. It sits directly downstream of the `gpu` top level. It consumes the `instruction_mem_read_valid/address` channel bundle and returns `instruction_mem_read_ready/data`. Its memory side drives a BRAM or AXI-bridge read port with a valid/ready handshake.

---
 rtl/instr_mem_controller_pkg.sv | 20 ++
 rtl/instr_mem_controller_if.sv | 50 +++++
 rtl/instr_mem_controller_rr_arbiter.sv | 31 +++
 rtl/instr_mem_controller.sv | 112 +++++++++++
 tb/tb_instr_mem_controller.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_controller_pkg.sv
// Shared types and widths for the GPU instruction-memory controller.
// Width constants stand in for the GPU-wide common width definitions.
package instr_mem_controller_pkg;

    localparam int INSTRUCTION_MEMORY_ADDRESS_WIDTH = 16;
    localparam int INSTRUCTION_WIDTH = 32;
    localparam int NUM_FETCH_CHANNELS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } instr_mem_ctrl_state_t;

    // Index k positions after idx, wrapping modulo n.
    function automatic int wrap_inc(int idx, int k, int n);
        return (idx + k) % n;
    endfunction

endpackage

// File: rtl/instr_mem_controller_if.sv
// Fetch-channel bundle from the GPU and the single memory read port.
// master drives the request side, slave answers it.
interface imc_ch_if #(
    parameter int NUM_CHANNELS = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic [NUM_CHANNELS-1:0] ch_read_valid;
    logic [ADDR_WIDTH-1:0] ch_read_address [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] ch_read_ready;
    logic [DATA_WIDTH-1:0] ch_read_data [NUM_CHANNELS];

    modport master (
        output ch_read_valid,
        output ch_read_address,
        input ch_read_ready,
        input ch_read_data
    );

    modport slave (
        input ch_read_valid,
        input ch_read_address,
        output ch_read_ready,
        output ch_read_data
    );
endinterface

interface imc_mem_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
);
    logic mem_read_valid;
    logic [ADDR_WIDTH-1:0] mem_read_address;
    logic mem_read_ready;
    logic [DATA_WIDTH-1:0] mem_read_data;

    modport master (
        output mem_read_valid,
        output mem_read_address,
        input mem_read_ready,
        input mem_read_data
    );

    modport slave (
        input mem_read_valid,
        input mem_read_address,
        output mem_read_ready,
        output mem_read_data
    );
endinterface

// File: rtl/instr_mem_controller_rr_arbiter.sv
// Combinational round-robin arbiter; search begins just after last_grant.
// Shared with the data-memory controller.
module rr_arbiter
    import instr_mem_controller_pkg::*;
#(
    parameter int N = 8
) (
    input logic [N-1:0] req,
    input logic [$clog2(N)-1:0] last_grant,
    output logic grant_valid,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int W = $clog2(N);

    logic [W-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx = '0;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            idx = W'(wrap_inc(int'(last_grant), k, N));
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_idx = idx;
            end
        end
    end

endmodule

// File: rtl/instr_mem_controller.sv
// Arbitrates per-channel instruction fetches onto one memory read port,
// one outstanding transaction at a time.
module instr_mem_controller
    import instr_mem_controller_pkg::*;
#(
    parameter int NUM_CHANNELS = NUM_FETCH_CHANNELS,
    parameter int ADDR_WIDTH = INSTRUCTION_MEMORY_ADDRESS_WIDTH,
    parameter int DATA_WIDTH = INSTRUCTION_WIDTH
) (
    input logic clk,
    input logic reset,
    imc_ch_if.slave ch,
    imc_mem_if.master mem
);
    localparam int GW = $clog2(NUM_CHANNELS);

    instr_mem_ctrl_state_t state;
    instr_mem_ctrl_state_t state_next;

    logic [GW-1:0] grant_idx;
    logic [GW-1:0] last_grant;
    logic [GW-1:0] arb_idx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [NUM_CHANNELS-1:0] served;
    logic [NUM_CHANNELS-1:0] eligible;
    logic [NUM_CHANNELS-1:0] rdy;
    logic arb_valid;
    logic arbitrate;

    // The channel being answered is masked so a held valid is not re-served.
    assign eligible = ch.ch_read_valid & ~served & ~rdy;
    assign arbitrate = (state == IDLE) || (state == RESP);

    rr_arbiter #(
        .N(NUM_CHANNELS)
    ) u_arb (
        .req(eligible),
        .last_grant(last_grant),
        .grant_valid(arb_valid),
        .grant_idx(arb_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (arb_valid) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (mem.mem_read_ready) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = arb_valid ? REQ : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        mem.mem_read_valid = (state == REQ);
        mem.mem_read_address = (state == REQ) ? addr_q : '0;
        rdy = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            rdy[i] = (state == RESP) && (grant_idx == GW'(i));
            ch.ch_read_data[i] = rdy[i] ? data_q : '0;
        end
        ch.ch_read_ready = rdy;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_idx <= '0;
            addr_q <= '0;
            data_q <= '0;
            last_grant <= GW'(NUM_CHANNELS - 1);
        end else begin
            if (arbitrate && arb_valid) begin
                grant_idx <= arb_idx;
                addr_q <= ch.ch_read_address[arb_idx];
                last_grant <= arb_idx;
            end
            if ((state == REQ) && mem.mem_read_ready) begin
                data_q <= mem.mem_read_data;
            end
        end
    end

    // A dropped valid re-arms the channel for its next request.
    always_ff @(posedge clk) begin
        if (reset) begin
            served <= '0;
        end else begin
            served <= ch.ch_read_valid & (served | rdy);
        end
    end

endmodule

// File: tb/tb_instr_mem_controller.sv
// Self-checking bench for instr_mem_controller: directed scenarios
// followed by randomized traffic against a transaction-level model.
module tb_instr_mem_controller;
    import instr_mem_controller_pkg::*;

    localparam int N = 8;
    localparam int AW = 16;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imc_ch_if #(.NUM_CHANNELS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ch ();
    imc_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem ();

    instr_mem_controller #(
        .NUM_CHANNELS(N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ch(ch),
        .mem(mem)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int mem_mode = 0;
    int wait_cfg = 0;
    int wcnt = 0;
    int wtarget = 0;

    int obs_ch[$];
    int obs_cyc[$];
    logic [DW-1:0] obs_dat[$];

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_fn(logic [AW-1:0] a, int mode);
        case (mode)
            0: return DW'(a);
            1: return 32'hDEADBEEF;
            default: return {a, ~a};
        endcase
    endfunction

    // Memory responder: waits wtarget cycles per request.
    always @(negedge clk) begin
        mem.mem_read_data = mem_fn(mem.mem_read_address, mem_mode);
        if (mem.mem_read_valid) begin
            mem.mem_read_ready = (wcnt >= wtarget);
            wcnt++;
        end else begin
            mem.mem_read_ready = 1'($urandom_range(0, 1));
            wcnt = 0;
            wtarget = (wait_cfg < 0) ? $urandom_range(0, 3) : wait_cfg;
        end
    end

    // Reference model: one pending fetch, one answer, fairness pointer.
    bit armed = 0;
    bit m_wait, m_ans;
    int m_ch, m_last, pulse, pick, c;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_word;
    bit m_served[N];
    bit elig[N];
    logic [N-1:0] exp_rdy;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (reset) begin
            armed = 1;
            m_wait = 0;
            m_ans = 0;
            m_ch = 0;
            m_last = N - 1;
            m_addr = '0;
            m_word = '0;
            for (int i = 0; i < N; i++) m_served[i] = 0;
        end else begin
            pulse = m_ans ? m_ch : -1;
            for (int i = 0; i < N; i++) begin
                elig[i] = ch.ch_read_valid[i] && !m_served[i] && i != pulse;
                m_served[i] = ch.ch_read_valid[i] && (m_served[i] || i == pulse);
            end
            if (m_wait) begin
                if (mem.mem_read_ready) begin
                    m_word = mem_fn(m_addr, mem_mode);
                    m_wait = 0;
                    m_ans = 1;
                end
            end else begin
                m_ans = 0;
                pick = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (pick < 0 && elig[c]) pick = c;
                end
                if (pick >= 0) begin
                    m_wait = 1;
                    m_ch = pick;
                    m_addr = ch.ch_read_address[pick];
                    m_last = pick;
                end
            end
        end
        if (armed) begin
            exp_rdy = '0;
            if (m_ans) exp_rdy[m_ch] = 1'b1;
            check("mem_valid", 64'(mem.mem_read_valid), 64'(m_wait));
            check("mem_addr", 64'(mem.mem_read_address),
                  m_wait ? 64'(m_addr) : 64'd0);
            check("ch_ready", 64'(ch.ch_read_ready), 64'(exp_rdy));
            for (int i = 0; i < N; i++) begin
                check("ch_data", 64'(ch.ch_read_data[i]),
                      exp_rdy[i] ? 64'(m_word) : 64'd0);
            end
            for (int i = 0; i < N; i++) begin
                if (ch.ch_read_ready[i] === 1'b1) begin
                    obs_ch.push_back(i);
                    obs_cyc.push_back(cyc);
                    obs_dat.push_back(ch.ch_read_data[i]);
                end
            end
        end
    end

    task automatic clear_obs();
        obs_ch.delete();
        obs_cyc.delete();
        obs_dat.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        ch.ch_read_valid = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        clear_obs();
    endtask

    task automatic wait_rdy(int chn, int lim, string nm);
        int n = 0;
        while (ch.ch_read_ready[chn] !== 1'b1 && n < lim) begin
            @(negedge clk);
            n++;
        end
        check(nm, 64'(ch.ch_read_ready[chn]), 64'd1);
    endtask

    function automatic int count_ch(int chn);
        int n = 0;
        foreach (obs_ch[k]) if (obs_ch[k] == chn) n++;
        return n;
    endfunction

    initial begin
        int reps;
        reset = 1'b1;
        ch.ch_read_valid = '0;
        for (int i = 0; i < N; i++) ch.ch_read_address[i] = '0;

        // Reset state
        do_reset();
        @(posedge clk);
        #2;
        check("rst_mem_valid", 64'(mem.mem_read_valid), 64'd0);
        check("rst_mem_addr", 64'(mem.mem_read_address), 64'd0);
        check("rst_ready", 64'(ch.ch_read_ready), 64'd0);
        check("rst_data0", 64'(ch.ch_read_data[0]), 64'd0);

        // Single request, zero-wait memory
        do_reset();
        mem_mode = 1;
        wait_cfg = 0;
        ch.ch_read_address[3] = 16'h0010;
        ch.ch_read_valid[3] = 1'b1;
        @(posedge clk);
        #2;
        check("single_mv_t1", 64'(mem.mem_read_valid), 64'd1);
        check("single_ma_t1", 64'(mem.mem_read_address), 64'h10);
        @(posedge clk);
        #2;
        check("single_rdy_t2", 64'(ch.ch_read_ready), 64'h08);
        check("single_data_t2", 64'(ch.ch_read_data[3]), 64'hDEADBEEF);
        @(negedge clk);
        ch.ch_read_valid[3] = 1'b0;

        // All channels at once
        do_reset();
        mem_mode = 0;
        for (int i = 0; i < N; i++) begin
            ch.ch_read_address[i] = AW'(i);
            ch.ch_read_valid[i] = 1'b1;
        end
        repeat (24) begin
            @(negedge clk);
            for (int i = 0; i < N; i++)
                if (ch.ch_read_ready[i]) ch.ch_read_valid[i] = 1'b0;
        end
        check("all_count", 64'(obs_ch.size()), 64'd8);
        foreach (obs_ch[k]) begin
            check("all_order", 64'(obs_ch[k]), 64'(k));
            check("all_data", 64'(obs_dat[k]), 64'(k));
            if (k > 0)
                check("all_spacing", 64'(obs_cyc[k] - obs_cyc[k-1]), 64'd2);
        end

        // Held valid after ready
        do_reset();
        mem_mode = 2;
        ch.ch_read_address[5] = 16'h0055;
        ch.ch_read_valid[5] = 1'b1;
        wait_rdy(5, 10, "hold_first_timeout");
        repeat (3) @(negedge clk);
        check("hold_one_pulse", 64'(count_ch(5)), 64'd1);
        ch.ch_read_valid[5] = 1'b0;
        @(negedge clk);
        ch.ch_read_valid[5] = 1'b1;
        repeat (6) @(negedge clk);
        check("hold_second_pulse", 64'(count_ch(5)), 64'd2);
        ch.ch_read_valid[5] = 1'b0;

        // Memory wait states
        do_reset();
        wait_cfg = 4;
        ch.ch_read_address[2] = 16'h0222;
        ch.ch_read_valid[2] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #2;
            check("wait_mv", 64'(mem.mem_read_valid), 64'd1);
            check("wait_ma", 64'(mem.mem_read_address), 64'h0222);
        end
        @(posedge clk);
        #2;
        check("wait_rdy_t6", 64'(ch.ch_read_ready), 64'h04);
        check("wait_data", 64'(ch.ch_read_data[2]), 64'h0222FDDD);
        @(negedge clk);
        ch.ch_read_valid[2] = 1'b0;
        wait_cfg = 0;

        // Fairness between two re-requesting channels
        do_reset();
        mem_mode = 0;
        ch.ch_read_address[0] = 16'h0000;
        ch.ch_read_address[1] = 16'h0001;
        ch.ch_read_valid[1:0] = 2'b11;
        repeat (16) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (ch.ch_read_ready[i]) ch.ch_read_valid[i] = 1'b0;
                else if (!ch.ch_read_valid[i]) ch.ch_read_valid[i] = 1'b1;
            end
        end
        ch.ch_read_valid[1:0] = 2'b00;
        check("fair_enough", 64'(obs_ch.size() >= 4), 64'd1);
        reps = 0;
        foreach (obs_ch[k]) begin
            if (k < 4) check("fair_order", 64'(obs_ch[k]), 64'(k % 2));
            if (k > 0 && obs_ch[k] == obs_ch[k-1]) reps++;
        end
        check("fair_no_repeat", 64'(reps), 64'd0);

        // Reset during a waiting REQ
        do_reset();
        mem_mode = 2;
        wait_cfg = 10;
        ch.ch_read_address[4] = 16'h0044;
        ch.ch_read_valid[4] = 1'b1;
        @(negedge clk);
        ch.ch_read_address[0] = 16'h0040;
        ch.ch_read_valid[0] = 1'b1;
        @(negedge clk);
        check("rreq_in_req", 64'(mem.mem_read_valid), 64'd1);
        wait_cfg = 0;
        reset = 1'b1;
        @(posedge clk);
        #2;
        check("rreq_mv", 64'(mem.mem_read_valid), 64'd0);
        check("rreq_ma", 64'(mem.mem_read_address), 64'd0);
        check("rreq_rdy", 64'(ch.ch_read_ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        clear_obs();
        wait_rdy(0, 20, "rreq_ch0_timeout");
        check("rreq_first_ch0", 64'(obs_ch.size() > 0 ? obs_ch[0] : -1), 64'd0);
        ch.ch_read_valid = '0;

        // Randomized traffic
        do_reset();
        mem_mode = 2;
        wait_cfg = -1;
        repeat (3000) begin
            @(negedge clk);
            reset = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < N; i++) begin
                if (ch.ch_read_valid[i]) begin
                    if (ch.ch_read_ready[i] ? ($urandom_range(0, 1) == 0)
                                            : ($urandom_range(0, 31) == 0))
                        ch.ch_read_valid[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    ch.ch_read_address[i] = AW'($urandom);
                    ch.ch_read_valid[i] = 1'b1;
                end
            end
        end
        check("rand_progress", 64'(obs_ch.size() > 100), 64'd1);
        reset = 1'b0;
        ch.ch_read_valid = '0;
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
